sdf_acc_rr: RTL



---
 rtl/sdf_acc_rr_if.sv | 24 ++
 rtl/sdf_acc_rr.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sdf_acc_rr_if.sv
// Token-side and output-side handshake bundle of the sdf_acc_rr accumulate actor.
// The fabric (input FIFOs and the output FIFO) takes the master side; the actor takes the slave side.
interface sdf_acc_rr_if #(
  parameter int PORTS = 2,
  parameter int FLUX  = 2,
  parameter int WIDTH = 8
);
  logic [WIDTH*PORTS*FLUX-1:0] in_data;
  logic [PORTS*FLUX-1:0]       in_empty;
  logic [PORTS*FLUX-1:0]       in_read;
  logic                        out0_full;
  logic                        out0_wr;
  logic [WIDTH-1:0]            out0_data;

  modport master (
    output in_data, in_empty, out0_full,
    input  in_read, out0_wr, out0_data
  );

  modport slave (
    input  in_data, in_empty, out0_full,
    output in_read, out0_wr, out0_data
  );
endinterface

// File: rtl/sdf_acc_rr.sv
// Multi-flux SDF accumulate actor with round-robin arbitration and optional block lock.
// Define SDF_ACC_SAT_EN for unsigned saturating accumulation; otherwise sums wrap modulo 2^DW.
module sdf_acc_rr #(
  parameter int PORTS    = 2,
  parameter int FLUX     = 2,
  parameter int WIDTH    = 8,
  parameter int NUM_OP   = 4,
  parameter bit EMIT_ALL = 1'b1,
  parameter bit LOCK     = 1'b1
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         flush,
  sdf_acc_rr_if.slave  bus
);
  localparam int TW = $clog2(FLUX);
  localparam int DW = WIDTH - TW;
  localparam int CW = $clog2(NUM_OP);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_OP - 1);

  localparam logic [0:0] ST_FREE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [DW-1:0]   acc [FLUX];
  logic [CW-1:0]   cnt [FLUX];
  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   lock_f;
  logic [0:0]      state;

  logic [FLUX-1:0] ready;
  logic [FLUX-1:0] cand;
  logic [TW-1:0]   sel;
  logic [TW-1:0]   probe;
  logic            found;
  logic            fire;
  logic            last;
  logic [DW-1:0]   sum;
  logic [DW:0]     step_sum;

  function automatic logic [TW-1:0] rr_add(input logic [TW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= FLUX) s = s - FLUX;
    return TW'(s);
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    ready = '0;
    for (int f = 0; f < FLUX; f++) ready[f] = ~|bus.in_empty[f*PORTS +: PORTS];

    cand = ready;
    if (LOCK && state == ST_HELD) begin
      cand         = '0;
      cand[lock_f] = ready[lock_f];
    end

    sel   = '0;
    probe = '0;
    found = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      probe = rr_add(rr_ptr, i);
      if (!found && cand[probe]) begin
        found = 1'b1;
        sel   = probe;
      end
    end
  end

  assign fire = found & ~bus.out0_full & ~flush & ~rst;
  assign last = (cnt[sel] == CNT_LAST);

  // Each port is added one at a time so saturation clamps after every addition.
  always_comb begin
    sum      = acc[sel];
    step_sum = '0;
    for (int p = 0; p < PORTS; p++) begin
      step_sum = {1'b0, sum} + {1'b0, bus.in_data[(int'(sel)*PORTS + p)*WIDTH +: DW]};
`ifdef SDF_ACC_SAT_EN
      sum = step_sum[DW] ? {DW{1'b1}} : step_sum[DW-1:0];
`else
      sum = step_sum[DW-1:0];
`endif
    end
  end

  always_comb begin
    bus.in_read = '0;
    if (fire) bus.in_read[int'(sel)*PORTS +: PORTS] = {PORTS{1'b1}};
    bus.out0_wr   = fire & (EMIT_ALL | last);
    bus.out0_data = bus.out0_wr ? {sel, sum} : '0;
  end

  // NOTE: accumulators live in flops, not RAM, because flush must clear every flux in one cycle.
  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge ck) begin
    if (rst || flush) begin
      for (int f = 0; f < FLUX; f++) begin
        acc[f] <= '0;
        cnt[f] <= '0;
      end
      rr_ptr <= '0;
      lock_f <= '0;
      state  <= ST_FREE;
    end else if (fire) begin
      if (last) begin
        acc[sel] <= '0;
        cnt[sel] <= '0;
      end else begin
        acc[sel] <= sum;
        cnt[sel] <= cnt[sel] + CW'(1);
      end
      rr_ptr <= rr_add(sel, 1);
      if (LOCK) begin
        case (state)
          ST_FREE: if (!last) begin
            state  <= ST_HELD;
            lock_f <= sel;
          end
          ST_HELD: if (last) state <= ST_FREE;
          default: state <= ST_FREE;
        endcase
      end
    end
  end
endmodule
